ones_enum: RTL and testbench

Sequential enumerator: the inverse of the 6-bit ones counter. Given a requested ones-count `k`, it emits every 6-bit value with exactly `k` bits set, in ascending numeric order, one value per valid/ready handshake. It sits beside the ones counter as a stimulus and pattern source for test datapaths, where it feeds any downstream consumer that has a ready/valid input.

---
 rtl/ones_enum_pkg.sv | 50 +++++
 rtl/ones_enum_pop.sv | 19 +
 rtl/ones_enum.sv | 175 +++++++++++++++++
 tb/tb_ones_enum.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ones_enum_pkg.sv
// Shared types and helpers for the ones_enum k-of-6 pattern source.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. ONES_ENUM_GOSPER_EN selects the direct next-permutation datapath.
package ones_enum_pkg;

  localparam int ONES_W  = 6;  // data width
  localparam int ONES_KW = 3;  // ones-count width
  localparam int ONES_NW = 5;  // handed-off value counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Size of each k-of-6 set, C(6,k).
  localparam logic [ONES_NW-1:0] BINOM [0:6] = '{5'd1, 5'd6, 5'd15, 5'd20, 5'd15, 5'd6, 5'd1};

  // Smallest value with k ones: 2^k - 1.
  function automatic logic [ONES_W-1:0] ones_mask(input logic [ONES_KW-1:0] k);
    return 6'((7'd1 << k) - 7'd1);
  endfunction

  // Largest value with k ones: the mask pushed to the top of the word.
  function automatic logic [ONES_W-1:0] last_val(input logic [ONES_KW-1:0] k);
    return ones_mask(k) << (3'd6 - k);
  endfunction

  // Next larger value with the same popcount: isolate the lowest set bit,
  // ripple it upward, then re-justify the displaced ones at the bottom.
  // Worked in 7 bits so the carry out of the top is never silently lost.
  function automatic logic [ONES_W-1:0] gosper_next(input logic [ONES_W-1:0] x);
    logic [6:0] xe;
    logic [6:0] c;
    logic [6:0] r;
    logic [6:0] t;
    int         sh;
    xe = {1'b0, x};
    c  = xe & (~xe + 7'd1);
    r  = xe + c;
    t  = (r ^ xe) >> 2;
    sh = 0;
    for (int i = 0; i < 7; i++) begin
      if (c[i]) sh = i;
    end
    t = t >> sh;
    return 6'(t | r);
  endfunction

endpackage

// File: rtl/ones_enum_pop.sv
// Combinational 6-bit population count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
module ones_enum_pop
  import ones_enum_pkg::*;
(
  input  logic [ONES_W-1:0]  d,
  output logic [ONES_KW-1:0] cnt
);

  // Sum the set bits; 3 bits is enough for a maximum of 6.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < ONES_W; i++) begin
      cnt = cnt + {2'b00, d[i]};
    end
  end

endmodule

// File: rtl/ones_enum.sv
// Enumerates every 6-bit value with exactly k ones, ascending; ONES_ENUM_GOSPER_EN = gapless next-permutation mode.
// Latency: first o_valid 1 cycle after start (ONES_ENUM_GOSPER_EN) or 2^k cycles (default scan); done 1 cycle after last handshake.
// Backpressure: valid/ready; o and o_last hold while o_valid && !o_ready; all outputs registered.
module ones_enum
  import ones_enum_pkg::*;
#(
  parameter int W = ONES_W
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ONES_KW-1:0] k,
  input  logic               o_ready,
  output logic               o_valid,
  output logic [W-1:0]       o,
  output logic               o_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ONES_NW-1:0] n_out
);

  state_e             state_q, state_d;
  logic [ONES_KW-1:0] k_q, k_d;
  logic [ONES_W-1:0]  o_q, o_d;
  logic               o_valid_q, o_valid_d;
  logic               o_last_q, o_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ONES_NW-1:0] n_out_q, n_out_d;
  logic               hs;

`ifdef ONES_ENUM_GOSPER_EN
  logic [ONES_W-1:0]  nxt_val;

  assign nxt_val = gosper_next(o_q);
`else
  // Scan counter carries a 7th bit so running off the end of 0..63 is visible.
  logic [6:0]         cnt_q, cnt_d;
  logic [6:0]         cnt_nxt;
  logic [ONES_KW-1:0] cand_pop;

  assign cnt_nxt = cnt_q + 7'd1;

  ones_enum_pop u_pop (
    .d   (cnt_nxt[ONES_W-1:0]),
    .cnt (cand_pop)
  );
`endif

  assign hs = o_valid_q & o_ready;

  // Next-state and next-output logic; o_ready only ever reaches _d signals.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    n_out_d   = n_out_q;
`ifndef ONES_ENUM_GOSPER_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          n_out_d = '0;
          err_d   = 1'b0;
          if (k == 3'd7) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
`ifdef ONES_ENUM_GOSPER_EN
            o_d       = ones_mask(k);
            o_valid_d = 1'b1;
            o_last_d  = (ones_mask(k) == last_val(k));
`else
            // Candidate 0 is shown first; it only matches when k is 0.
            cnt_d     = '0;
            o_d       = '0;
            o_valid_d = (k == 3'd0);
            o_last_d  = (k == 3'd0);
`endif
          end
        end
      end
      RUN: begin
        if (hs) begin
          n_out_d = (n_out_q == '1) ? n_out_q : n_out_q + 5'd1;
        end
        if (hs && o_last_q) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
        end else if (!o_valid_q || o_ready) begin
`ifdef ONES_ENUM_GOSPER_EN
          o_d       = nxt_val;
          o_valid_d = 1'b1;
          o_last_d  = (nxt_val == last_val(k_q));
`else
          cnt_d     = cnt_nxt;
          o_d       = cnt_nxt[ONES_W-1:0];
          o_valid_d = ~cnt_nxt[6] && (cand_pop == k_q);
          o_last_d  = ~cnt_nxt[6] && (cand_pop == k_q) &&
                      (cnt_nxt[ONES_W-1:0] == last_val(k_q));
          // The last value always precedes the wrap; close out defensively anyway.
          if (cnt_nxt[6]) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts any run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      n_out_q   <= '0;
`ifndef ONES_ENUM_GOSPER_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      n_out_q   <= n_out_d;
`ifndef ONES_ENUM_GOSPER_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign o_valid = o_valid_q;
  assign o       = o_q;
  assign o_last  = o_last_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign n_out   = n_out_q;

endmodule

// File: tb/tb_ones_enum.sv
// Directed bench for ones_enum: table of k-runs plus stall, mid-run start and mid-run reset sequences.
// Latency: first-valid spacing expected per build (ONES_ENUM_GOSPER_EN or scan).
// Backpressure: o_ready driven always-high or in a 1-0-0-1 pattern.
module tb_ones_enum;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] k;
  logic       o_ready;
  logic       o_valid;
  logic [5:0] o;
  logic       o_last;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] n_out;
  logic [2:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int BUDGET = 400;

  ones_enum dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .k       (k),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o       (o),
    .o_last  (o_last),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .n_out   (n_out)
  );

  ones_enum_pop u_chk (
    .d   (o),
    .cnt (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] k;
    int         n;
    logic [5:0] first;
    logic [5:0] last;
    bit         err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check(nm, int'({o_valid, o_last, busy, done, err, o, n_out}), 0);
  endtask

  // Launch one run and watch it to the done pulse, then compare against expectations.
  task automatic do_run(input string nm, input logic [2:0] kk, input int exp_n,
                        input logic [5:0] exp_first, input logic [5:0] exp_last,
                        input bit exp_err, input bit toggle, input bit poke);
    logic [5:0] vals [$];
    int         c;
    int         done_c;
    int         first_v_c;
    int         last_hs_c;
    int         stalls;
    int         exp_lat;
    logic [4:0] nout_done;
    logic       err_done;
    bit         order_ok, pop_ok, last_ok, stall_ok, busy_ok;
    bit         pv, pr, plast, rdy;
    logic [5:0] po;
    bit   [3:0] pat;
    pat = 4'b1001;
    done_c = -1; first_v_c = -1; last_hs_c = -1; stalls = 0;
    nout_done = '0; err_done = 1'b0;
    order_ok = 1; pop_ok = 1; last_ok = 1; stall_ok = 1; busy_ok = 1;
    pv = 0; pr = 0; plast = 0; po = '0;
    start = 1'b1;
    k = kk;
    tick();
    start = 1'b0;
    c = 1;
    while (done_c < 0 && c < BUDGET) begin
      if (pv && !pr) begin
        stalls++;
        if (!o_valid || o != po || o_last != plast) stall_ok = 0;
      end
      rdy = toggle ? pat[c % 4] : 1'b1;
      o_ready = rdy;
      start = poke && (c == 3);
      k = (poke && c == 3) ? 3'd5 : kk;
      if (done) begin
        done_c = c;
        nout_done = n_out;
        err_done = err;
        if (busy) busy_ok = 0;
      end else if (busy != !exp_err) begin
        busy_ok = 0;
      end
      if (o_valid) begin
        if (first_v_c < 0) first_v_c = c;
        if (pc != kk) pop_ok = 0;
        if (o_last != (o == exp_last)) last_ok = 0;
        if (rdy) begin
          if (vals.size() > 0 && o <= vals[vals.size()-1]) order_ok = 0;
          vals.push_back(o);
          last_hs_c = c;
        end
      end else if (o_last) begin
        last_ok = 0;
      end
      pv = o_valid; pr = rdy; po = o; plast = o_last;
      tick();
      c++;
    end
    start = 1'b0;
    o_ready = 1'b1;
    check({nm, "/done_seen"}, int'(done_c >= 0), 1);
    check({nm, "/count"}, vals.size(), exp_n);
    if (exp_n > 0 && vals.size() > 0) begin
      check({nm, "/first"}, int'(vals[0]), int'(exp_first));
      check({nm, "/last"}, int'(vals[vals.size()-1]), int'(exp_last));
`ifdef ONES_ENUM_GOSPER_EN
      exp_lat = 1;
`else
      exp_lat = 1 << kk;
`endif
      check({nm, "/first_valid_cycle"}, first_v_c, exp_lat);
      check({nm, "/done_cycle"}, done_c, last_hs_c + 1);
    end else begin
      check({nm, "/err_done_cycle"}, done_c, 1);
      check({nm, "/no_valid"}, first_v_c, -1);
    end
    check({nm, "/ascending"}, int'(order_ok), 1);
    check({nm, "/popcount"}, int'(pop_ok), 1);
    check({nm, "/o_last"}, int'(last_ok), 1);
    check({nm, "/busy"}, int'(busy_ok), 1);
    check({nm, "/n_out_at_done"}, int'(nout_done), exp_n);
    check({nm, "/err_at_done"}, int'(err_done), int'(exp_err));
    if (toggle) check({nm, "/stall_hold"}, int'(stall_ok && stalls > 0), 1);
    check({nm, "/done_one_cycle"}, int'({done, busy, o_valid}), 0);
    check({nm, "/n_out_held"}, int'(n_out), exp_n);
  endtask

  initial begin
    int hs;
    int dn;
    vecs[0] = '{3'd2, 15, 6'b000011, 6'b110000, 1'b0};
    vecs[1] = '{3'd0,  1, 6'b000000, 6'b000000, 1'b0};
    vecs[2] = '{3'd6,  1, 6'b111111, 6'b111111, 1'b0};
    vecs[3] = '{3'd7,  0, 6'b000000, 6'b000000, 1'b1};
    vecs[4] = '{3'd1,  6, 6'b000001, 6'b100000, 1'b0};
    vecs[5] = '{3'd4, 15, 6'b001111, 6'b111100, 1'b0};
    vecs[6] = '{3'd5,  6, 6'b011111, 6'b111110, 1'b0};
    vecs[7] = '{3'd3, 20, 6'b000111, 6'b111000, 1'b0};

    rst_n = 1'b0; start = 1'b0; k = '0; o_ready = 1'b0;
    repeat (3) tick();
    check_idle("reset_state");
    rst_n = 1'b1;
    o_ready = 1'b1;
    tick();
    check_idle("idle_after_reset");

    // Table of runs with o_ready held high.
    for (int i = 0; i < 8; i++) begin
      do_run($sformatf("k%0d", vecs[i].k), vecs[i].k, vecs[i].n, vecs[i].first,
             vecs[i].last, vecs[i].err, 1'b0, 1'b0);
      tick();
      if (vecs[i].err) check($sformatf("k%0d/err_sticky", vecs[i].k), int'(err), 1);
      else             check($sformatf("k%0d/err_clear", vecs[i].k), int'(err), 0);
    end

    // k=3 under a 1-0-0-1 ready pattern.
    do_run("k3_stall", 3'd3, 20, 6'b000111, 6'b111000, 1'b0, 1'b1, 1'b0);
    tick();

    // Start with k=5 pulsed mid-run must not disturb the k=2 run.
    do_run("k2_poke", 3'd2, 15, 6'b000011, 6'b110000, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset after five handshakes of a k=4 run.
    start = 1'b1; k = 3'd4; o_ready = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < BUDGET && hs < 5; c++) begin
      if (o_valid) hs++;
      tick();
    end
    check("rst_mid/handshakes", hs, 5);
    check("rst_mid/n_out_before", int'(n_out), 5);
    rst_n = 1'b0;
    tick();
    check_idle("rst_mid/idle");
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || o_valid || busy) dn++;
      tick();
    end
    check("rst_mid/no_done", dn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
